// File: rtl/pattern_sequencer.sv
// Frame-aligned test-pattern select: synchronised, debounced switches and optional auto-cycling.
// Auto-cycling (AUTO state, frame counter, auto debouncer) exists only when PATTERN_SEQ_AUTO_EN is defined.

module pattern_seq_debounce #(
    parameter int W      = 1,
    parameter int CYCLES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    localparam int CW = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((CYCLES > 0) ? CYCLES - 1 : 0);

    logic [W-1:0]  prev_q;
    logic [W-1:0]  stable_q;
    logic [W-1:0]  stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q counts cycles the input has matched its previous value while differing from stable_q
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (i_d == prev_q && i_d != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = i_d;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            prev_q   <= i_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_q = stable_q;
endmodule

module pattern_sequencer #(
    parameter int DEBOUNCE_CYCLES    = 250000,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int NUM_PATTERNS       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_sw,
    input  logic       i_auto,
    input  logic       i_nf,
    output logic [1:0] o_sel,
    output logic       o_changed,
    output logic       o_auto
);
    localparam logic [2:0] NUM_L    = 3'(NUM_PATTERNS);
    localparam logic [1:0] SEL_LAST = 2'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        MANUAL_IDLE    = 2'd0,
        MANUAL_PENDING = 2'd1
`ifdef PATTERN_SEQ_AUTO_EN
        , AUTO         = 2'd2
`endif
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic       changed_q;
    logic       changed_d;
    logic [1:0] sw_meta_q;
    logic [1:0] sw_sync_q;
    logic [1:0] sw_stable;
    logic       sw_pend;
    logic       auto_stable;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= i_sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    pattern_seq_debounce #(
        .W      (2),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (sw_sync_q),
        .o_q   (sw_stable)
    );

    // Codes outside the pattern range never create a pending change
    assign sw_pend = ({1'b0, sw_stable} < NUM_L) && (sw_stable != sel_q);

`ifdef PATTERN_SEQ_AUTO_EN
    localparam int FW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_PATTERN - 1);

    logic          auto_meta_q;
    logic          auto_sync_q;
    logic [FW-1:0] fcnt_q;
    logic [FW-1:0] fcnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            auto_meta_q <= 1'b0;
            auto_sync_q <= 1'b0;
        end else begin
            auto_meta_q <= i_auto;
            auto_sync_q <= auto_meta_q;
        end
    end

    pattern_seq_debounce #(
        .W      (1),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_auto_db (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (auto_sync_q),
        .o_q   (auto_stable)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end
`else
    logic auto_unused;
    assign auto_unused = i_auto;
    assign auto_stable = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        changed_d = 1'b0;
`ifdef PATTERN_SEQ_AUTO_EN
        fcnt_d    = '0;
`endif
        case (state_q)
            MANUAL_IDLE: begin
`ifdef PATTERN_SEQ_AUTO_EN
                if (auto_stable) begin
                    state_d = AUTO;
                end else
`endif
                if (sw_pend) begin
                    state_d = MANUAL_PENDING;
                end
            end
            MANUAL_PENDING: begin
`ifdef PATTERN_SEQ_AUTO_EN
                if (auto_stable) begin
                    state_d = AUTO;
                end else
`endif
                if (!sw_pend) begin
                    state_d = MANUAL_IDLE;
                end else if (i_nf) begin
                    sel_d     = sw_stable;
                    changed_d = 1'b1;
                    state_d   = MANUAL_IDLE;
                end
            end
`ifdef PATTERN_SEQ_AUTO_EN
            AUTO: begin
                fcnt_d = fcnt_q;
                // Leaving auto mode wins over a same-cycle advance
                if (!auto_stable) begin
                    state_d = sw_pend ? MANUAL_PENDING : MANUAL_IDLE;
                end else if (i_nf) begin
                    if (fcnt_q == FLAST) begin
                        fcnt_d = '0;
                        if (NUM_PATTERNS > 1) begin
                            sel_d     = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
                            changed_d = 1'b1;
                        end
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
`endif
            default: state_d = MANUAL_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= MANUAL_IDLE;
            sel_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            changed_q <= changed_d;
        end
    end

    assign o_sel     = sel_q;
    assign o_changed = changed_q;
    assign o_auto    = auto_stable;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: vector table of switch/auto settings plus a pulse scoreboard.
module tb_pattern_sequencer;
    logic       clk;
    logic       rst;
    logic [1:0] sw;
    logic       auto_in;
    logic       nf;
    logic [1:0] sel;
    logic       changed;
    logic       auto_out;

    int checks   = 0;
    int failures = 0;
    int nf_cd    = 20;

    logic [1:0] exp_q[$];
    logic [1:0] last_sel = 2'd0;
    logic       chg_last = 1'b0;
    logic       nf_last  = 1'b0;

    typedef struct {
        logic [1:0] sw;
        logic       auto_in;
        int         nfs;
        logic [1:0] pre;
        logic [1:0] exp_sel;
        logic       exp_auto;
        int         npush;
        logic [7:0] pushes;
    } vec_t;

    vec_t vecs[$];

    pattern_sequencer #(
        .DEBOUNCE_CYCLES    (4),
        .FRAMES_PER_PATTERN (3),
        .NUM_PATTERNS       (4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sw      (sw),
        .i_auto    (auto_in),
        .i_nf      (nf),
        .o_sel     (sel),
        .o_changed (changed),
        .o_auto    (auto_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One cycle; drives the free-running frame pulse from its countdown
    task automatic tick();
        @(posedge clk);
        #1;
        if (nf_cd <= 1) begin
            nf    = 1'b1;
            nf_cd = 20;
        end else begin
            nf    = 1'b0;
            nf_cd = nf_cd - 1;
        end
    endtask

    task automatic wait_nfs(input int n, input logic [1:0] pre, input string name);
        int seen   = 0;
        int budget = 0;
        while (seen < n && budget < 30 * n + 30) begin
            tick();
            budget++;
            if (nf) begin
                seen++;
                if (seen == n) check({name, "_pre"}, sel, pre);
            end
        end
        if (seen < n) begin
            failures++;
            $display("FAIL %s_timeout saw=%0d frames expected=%0d", name, seen, n);
        end
        tick();
        tick();
    endtask

    function automatic vec_t mk(input logic [1:0] s, input logic a, input int n, input logic [1:0] p,
                                input logic [1:0] e, input logic ea, input int np, input logic [7:0] pu);
        vec_t v;
        v.sw = s; v.auto_in = a; v.nfs = n; v.pre = p; v.exp_sel = e;
        v.exp_auto = ea; v.npush = np; v.pushes = pu;
        return v;
    endfunction

    // Scoreboard side: every o_changed pulse must be expected, follow an i_nf and last one cycle
    always @(negedge clk) begin
        if (rst) begin
            last_sel = sel;
            chg_last = 1'b0;
            nf_last  = nf;
        end else begin
            if (sel != last_sel) check("sel_change_has_pulse", changed, 1);
            if (changed) begin
                check("changed_after_nf", nf_last, 1);
                check("changed_single_cycle", chg_last, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_changed sel=%0d expected no pulse", sel);
                end else begin
                    check("changed_sel", sel, exp_q.pop_front());
                end
            end
            last_sel = sel;
            chg_last = changed;
            nf_last  = nf;
        end
    end

    initial begin
        rst = 1'b1; sw = 2'd0; auto_in = 1'b0; nf = 1'b0;

        vecs.push_back(mk(2'd0, 1'b0, 2, 2'd0, 2'd0, 1'b0, 0, 8'h00));
        vecs.push_back(mk(2'd2, 1'b0, 1, 2'd0, 2'd2, 1'b0, 1, 8'h02));
        vecs.push_back(mk(2'd0, 1'b0, 1, 2'd2, 2'd0, 1'b0, 1, 8'h00));
        vecs.push_back(mk(2'd3, 1'b0, 1, 2'd0, 2'd3, 1'b0, 1, 8'h03));
        vecs.push_back(mk(2'd3, 1'b0, 2, 2'd3, 2'd3, 1'b0, 0, 8'h00));
        vecs.push_back(mk(2'd1, 1'b0, 1, 2'd3, 2'd1, 1'b0, 1, 8'h01));
        vecs.push_back(mk(2'd0, 1'b0, 1, 2'd1, 2'd0, 1'b0, 1, 8'h00));
`ifdef PATTERN_SEQ_AUTO_EN
        vecs.push_back(mk(2'd0, 1'b1, 12, 2'd3, 2'd0, 1'b1, 4, 8'b00_11_10_01));
`else
        vecs.push_back(mk(2'd0, 1'b1, 3, 2'd0, 2'd0, 1'b0, 0, 8'h00));
`endif
        vecs.push_back(mk(2'd0, 1'b0, 1, 2'd0, 2'd0, 1'b0, 0, 8'h00));

        repeat (3) tick();
        check("reset_sel", sel, 0);
        check("reset_changed", changed, 0);
        check("reset_auto", auto_out, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            sw      = vecs[i].sw;
            auto_in = vecs[i].auto_in;
            nf_cd   = 20;
            for (int p = 0; p < vecs[i].npush; p++) exp_q.push_back(vecs[i].pushes[2*p +: 2]);
            wait_nfs(vecs[i].nfs, vecs[i].pre, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
            check($sformatf("vec%0d_auto", i), auto_out, vecs[i].exp_auto);
        end

        // Short glitch must never reach the stable code
        nf_cd = 20;
        sw = 2'd3;
        repeat (3) tick();
        sw = 2'd0;
        wait_nfs(2, 2'd0, "glitch");
        check("glitch_sel", sel, 0);

        // Debounce completes on the same edge that samples i_nf
        sw    = 2'd1;
        nf_cd = 6;
        exp_q.push_back(2'd1);
        wait_nfs(1, 2'd0, "coincide_first");
        check("coincide_hold", sel, 0);
        wait_nfs(1, 2'd0, "coincide_second");
        check("coincide_sel", sel, 1);

        // Reset while a change to 3 is pending
        sw    = 2'd3;
        nf_cd = 20;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        tick();
        check("midrst_sel", sel, 0);
        check("midrst_changed", changed, 0);
        rst   = 1'b0;
        nf_cd = 20;
        exp_q.push_back(2'd3);
        wait_nfs(1, 2'd0, "midrst_reapply");
        check("midrst_reapply_sel", sel, 3);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Selects which test pattern the HDMI 480p pipeline displays and makes sure the selection only changes on a frame boundary. Inputs are the raw board switches and an auto-cycle control. Both are synchronised and debounced, and the block cycles through the patterns automatically when auto mode is on. It sits in the 25 MHz pixel domain between the board switches, the video signal generator's new-frame pulse and the test pattern generator's select input.

## Interface
- `DEBOUNCE_CYCLES`, default 250000 — consecutive stable cycles before a switch change is accepted (10 ms at 25 MHz).
- `FRAMES_PER_PATTERN`, default 60 — frames each pattern is shown in auto mode; must be ≥ 1.
- `NUM_PATTERNS`, default 4 — number of valid select codes, 1..4.
- `i_clk`  in  1 — pixel clock; the only clock.
- `i_rst`  in  1 — reset; synchronous, active-high.
- `i_sw`  in  2 — raw, asynchronous pattern switches.
- `i_auto`  in  1 — raw, asynchronous auto-cycle enable.
- `i_nf`  in  1 — one-cycle new-frame pulse from the video signal generator.
- `o_sel`  out  2 — pattern select to the test pattern generator.
- `o_changed`  out  1 — one-cycle pulse: `o_sel` took a new value.
- `o_auto`  out  1 — debounced auto-mode state.

## Operation
**Input conditioning**
- `i_sw` and `i_auto` each pass through a 2-flop synchroniser.
- Each synchronised input has its own debouncer.
  - Counter width: `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter clears whenever the synchronised value differs from the previous cycle's value.
  - When the synchronised value differs from the stable value and has held for `DEBOUNCE_CYCLES` cycles, the stable value is updated and the counter clears.
- A debounced switch code ≥ `NUM_PATTERNS` is ignored: no pending change is created.

**FSM states**
- MANUAL_IDLE — `o_sel` equals the stable switch code.
  - Stable code changes to a valid value ≠ `o_sel` → MANUAL_PENDING.
  - Stable auto = 1 → AUTO.
- MANUAL_PENDING — waiting for a frame boundary.
  - On `i_nf`: `o_sel` ← stable code, `o_changed` ← 1, → MANUAL_IDLE.
  - If the stable code returns to `o_sel` before `i_nf`: → MANUAL_IDLE with no pulse.
  - Stable auto = 1 → AUTO.
- AUTO — on entry the frame counter clears and `o_sel` is held.
  - Each `i_nf` increments the frame counter (width `$clog2(FRAMES_PER_PATTERN)`, minimum 1).
  - On `i_nf` with counter = `FRAMES_PER_PATTERN-1`: counter ← 0, `o_sel` ← `o_sel+1`, wrapping from `NUM_PATTERNS-1` to 0, and `o_changed` ← 1.
  - `NUM_PATTERNS` = 1: `o_sel` stays 0 and `o_changed` never pulses.
  - Stable auto = 0 → MANUAL_PENDING if the stable code is valid and ≠ `o_sel`, otherwise → MANUAL_IDLE.

**Priority and boundary conditions**
- A debounce completion and `i_nf` in the same cycle: the new code is applied on the *next* `i_nf`, never the current one.
- Leaving AUTO takes priority over an advance in the same cycle: `o_sel` does not advance.
- `i_nf` pulses on consecutive cycles are each treated as a frame.

## Timing
- Reset (synchronous, `i_rst` = 1 on a rising edge):
  - `o_sel` = 0, `o_changed` = 0, `o_auto` = 0.
  - State = MANUAL_IDLE.
  - Synchronisers, stable values and all counters = 0.
- Reset asserted mid-operation aborts any pending change; no `o_changed` pulse is produced.
- Switch-to-stable latency: 2 (synchroniser) + `DEBOUNCE_CYCLES` + 1 cycles.
- `o_sel` and `o_changed` are registered on the same edge that samples `i_nf` high. The new value is visible in the cycle after the `i_nf` cycle.
- `o_changed` is high for exactly one cycle.
- `o_sel` never changes except on an `i_nf` edge or on reset.

## Configuration
- `PATTERN_SEQ_AUTO_EN` defined:
  - AUTO state, frame counter and auto debouncer are compiled in.
  - `o_auto` reflects the debounced `i_auto`.
- `PATTERN_SEQ_AUTO_EN` undefined:
  - AUTO state, frame counter and auto debouncer are removed.
  - `i_auto` is ignored and `o_auto` is tied to 0.
  - Only manual, frame-aligned switching remains.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `FRAMES_PER_PATTERN`=3, `NUM_PATTERNS`=4, `i_nf` every 20 cycles.
1. Reset release with `i_sw`=0 → `o_sel`=0 and `o_changed`=0 held indefinitely.
2. `i_sw` 0→2 held → no change before the next `i_nf`; `o_sel`=2 in the cycle after that `i_nf`; one `o_changed` pulse.
3. `i_sw` glitches to 3 for 3 cycles → `o_sel` stays 0; no `o_changed` pulse.
4. `i_auto`=1 (macro defined) → `o_sel` sequence 0,1,2,3,0, each step after 3 `i_nf` pulses; each step has one `o_changed` pulse.
5. Debounce of `i_sw`=1 completes in the same cycle as `i_nf` → `o_sel`=1 only after the following `i_nf`.
6. `i_rst` asserted while MANUAL_PENDING for code 3 → `o_sel`=0 and no pulse; after release, code 3 re-debounces and is applied on the next `i_nf`.
